mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 206 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: FSM sequencing, ALU decode,
// condition evaluation and flag register with gated write enables.
module mc_controller #(
  parameter int ALUW    = 3,
  parameter bit COND_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      op,
  input  logic [5:0]      funct,
  input  logic [3:0]      rd,
  input  logic [3:0]      cond,
  input  logic [3:0]      aluflags,
  output logic            pcwrite,
  output logic            memwrite,
  output logic            regwrite,
  output logic            irwrite,
  output logic            nextpc,
  output logic            adrsrc,
  output logic            alusrca,
  output logic [1:0]      resultsrc,
  output logic [1:0]      alusrcb,
  output logic [1:0]      immsrc,
  output logic [1:0]      regsrc,
  output logic [ALUW-1:0] alucontrol,
  output logic            undef
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  state_t          state, nxt;
  logic [3:0]      flags;
  logic            condex_q;
  logic            dp_ok, is_cmp, addsub, cond_ok;
  logic [ALUW-1:0] aluop;
  logic [1:0]      flagw;
  logic            irw, npc, regw, memw, branch, und, pcs;

  // ALU decode of the data-processing function field
  always_comb begin
    dp_ok  = 1'b1;
    is_cmp = 1'b0;
    addsub = 1'b0;
    aluop  = '0;
    unique case (funct[4:1])
      4'b0100: begin aluop = ALUW'(0); addsub = 1'b1; end
      4'b0010: begin aluop = ALUW'(1); addsub = 1'b1; end
      4'b0000: aluop = ALUW'(2);
      4'b1100: aluop = ALUW'(3);
      4'b0001: aluop = ALUW'(4);
      4'b1010: begin
        aluop  = ALUW'(1);
        is_cmp = (op == 2'b00);
      end
      default: dp_ok = 1'b0;
    endcase
    flagw = is_cmp ? 2'b11
          : {funct[0] & dp_ok, funct[0] & addsub};
  end

  // Condition field evaluated against the stored flags
  always_comb begin
    cond_ok = 1'b0;
    unique case (cond)
      4'h0: cond_ok = flags[2];
      4'h1: cond_ok = ~flags[2];
      4'h2: cond_ok = flags[1];
      4'h3: cond_ok = ~flags[1];
      4'h4: cond_ok = flags[3];
      4'h5: cond_ok = ~flags[3];
      4'h6: cond_ok = flags[0];
      4'h7: cond_ok = ~flags[0];
      4'h8: cond_ok = flags[1] & ~flags[2];
      4'h9: cond_ok = ~flags[1] | flags[2];
      4'hA: cond_ok = (flags[3] == flags[0]);
      4'hB: cond_ok = (flags[3] != flags[0]);
      4'hC: cond_ok = ~flags[2] & (flags[3] == flags[0]);
      4'hD: cond_ok = flags[2] | (flags[3] != flags[0]);
      4'hE: cond_ok = 1'b1;
      4'hF: cond_ok = 1'b0;
    endcase
  end

  // Next-state and per-state datapath controls
  always_comb begin
    nxt        = state;
    irw        = 1'b0;
    npc        = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    branch     = 1'b0;
    und        = 1'b0;
    adrsrc     = 1'b0;
    alusrca    = 1'b0;
    resultsrc  = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = '0;
    unique case (state)
      S_FETCH: begin
        irw       = 1'b1;
        npc       = 1'b1;
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        nxt       = S_DECODE;
      end
      S_DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        unique case (op)
          2'b01: nxt = S_MEMADR;
          2'b10: nxt = S_BRANCH;
          2'b00: begin
            if (!dp_ok) begin
              nxt = S_FETCH;
              und = 1'b1;
            end else if (funct[5]) begin
              nxt = S_EXECI;
            end else begin
              nxt = S_EXECR;
            end
          end
          default: begin
            nxt = S_FETCH;
            und = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrcb = 2'b01;
        nxt     = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        nxt    = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
        nxt       = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
        nxt    = S_FETCH;
      end
      S_EXECR: begin
        alucontrol = aluop;
        nxt        = S_ALUWB;
      end
      S_EXECI: begin
        alusrcb    = 2'b01;
        alucontrol = aluop;
        nxt        = S_ALUWB;
      end
      S_ALUWB: begin
        regw = 1'b1;
        nxt  = S_FETCH;
      end
      S_BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
        nxt       = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // State, condition latch and NZCV register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      flags    <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_DECODE)
        condex_q <= COND_EN ? cond_ok : 1'b1;
      if (state == S_EXECR || state == S_EXECI) begin
        if (flagw[1] & condex_q)
          flags[3:2] <= aluflags[3:2];
        if (flagw[0] & condex_q)
          flags[1:0] <= aluflags[1:0];
      end
    end
  end

  // Write enables are gated by the condition and held off in reset
  always_comb begin
    pcs      = ((rd == 4'hF) & regw) | branch;
    nextpc   = npc;
    irwrite  = irw & ~reset;
    pcwrite  = (npc | (pcs & condex_q)) & ~reset;
    regwrite = regw & condex_q & ~is_cmp & ~reset;
    memwrite = memw & condex_q & ~reset;
    undef    = und & ~reset;
    immsrc   = op;
    regsrc   = {(op == 2'b01) & ~funct[0], op == 2'b10};
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction-level model
// with randomized instruction stream and directed scenarios.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, aluflags;
  logic       pcwrite, memwrite, regwrite, irwrite;
  logic       nextpc, adrsrc, alusrca;
  logic [1:0] resultsrc, alusrcb, immsrc, regsrc;
  logic [2:0] alucontrol;
  logic       undef;

  mc_controller #(.ALUW(3), .COND_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .rd(rd), .cond(cond), .aluflags(aluflags),
    .pcwrite(pcwrite), .memwrite(memwrite),
    .regwrite(regwrite), .irwrite(irwrite),
    .nextpc(nextpc), .adrsrc(adrsrc), .alusrca(alusrca),
    .resultsrc(resultsrc), .alusrcb(alusrcb),
    .immsrc(immsrc), .regsrc(regsrc),
    .alucontrol(alucontrol), .undef(undef)
  );

  always #5 clk = ~clk;

  localparam int PCW = 18, MEMW = 17, REGW = 16, IRW = 15;
  localparam int UND = 0;

  int total = 0;
  int bad = 0;
  logic [3:0]  mflags;
  logic        mcx;
  logic [18:0] rec [0:4];
  int          last_lat;

  wire [18:0] dut_v = {pcwrite, memwrite, regwrite, irwrite,
                       nextpc, adrsrc, alusrca, resultsrc,
                       alusrcb, immsrc, regsrc, alucontrol, undef};

  task automatic lit(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic dp_supported(input logic [5:0] fn);
    case (fn[4:1])
      4'b0100, 4'b0010, 4'b0000,
      4'b1100, 4'b0001, 4'b1010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [5:0] fn);
    case (fn[4:1])
      4'b0100: return 3'd0;
      4'b0010: return 3'd1;
      4'b0000: return 3'd2;
      4'b1100: return 3'd3;
      4'b0001: return 3'd4;
      4'b1010: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic int latency(input logic [1:0] o,
                                 input logic [5:0] fn);
    if (o == 2'd1) return fn[0] ? 5 : 4;
    if (o == 2'd2) return 3;
    if (o == 2'd0 && dp_supported(fn)) return 4;
    return 2;
  endfunction

  function automatic logic holds(input logic [3:0] c,
                                 input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected output vector for cycle k of one instruction
  function automatic logic [18:0] expect_out(
      input int k, input logic [1:0] o, input logic [5:0] fn,
      input logic [3:0] r, input logic cx);
    logic [18:0] v;
    logic cmp, to_pc;
    v = '0;
    cmp = (o == 2'd0) && (fn[4:1] == 4'b1010);
    to_pc = (r == 4'hF) && cx;
    v[7:6] = o;
    v[5:4] = {(o == 2'd1) && !fn[0], o == 2'd2};
    if (k == 0) begin
      v[18] = 1'b1; v[15] = 1'b1; v[14] = 1'b1; v[12] = 1'b1;
      v[11:10] = 2'd2; v[9:8] = 2'd2;
    end else if (k == 1) begin
      v[12] = 1'b1; v[11:10] = 2'd2; v[9:8] = 2'd2;
      v[0] = (latency(o, fn) == 2);
    end else if (o == 2'd1) begin
      if (k == 2) v[9:8] = 2'd1;
      else if (k == 3) begin
        v[13] = 1'b1;
        if (!fn[0]) v[17] = cx;
      end else begin
        v[11:10] = 2'd1; v[16] = cx; v[18] = to_pc;
      end
    end else if (o == 2'd2) begin
      v[9:8] = 2'd1; v[11:10] = 2'd2; v[18] = cx;
    end else begin
      if (k == 2) begin
        v[9:8] = fn[5] ? 2'd1 : 2'd0;
        v[3:1] = alu_code(fn);
      end else begin
        v[16] = cx && !cmp; v[18] = to_pc;
      end
    end
    return v;
  endfunction

  // Runs one instruction (or its first n cycles when n>0);
  // called one time unit after the edge that starts its FETCH.
  task automatic run_instr(input logic [1:0] o, input logic [5:0] fn,
                           input logic [3:0] r, input logic [3:0] c,
                           input logic [3:0] af, input int n);
    int lat, cnt;
    logic [18:0] e;
    logic cmp, add, sub;
    lat = latency(o, fn);
    cnt = (n > 0) ? n : lat;
    last_lat = lat;
    op = o; funct = fn; rd = r; cond = c;
    cmp = (o == 2'd0) && (fn[4:1] == 4'b1010);
    add = fn[4:1] == 4'b0100;
    sub = fn[4:1] == 4'b0010;
    for (int k = 0; k < cnt; k++) begin
      aluflags = (k == 2) ? af : 4'($urandom);
      e = expect_out(k, o, fn, r, mcx);
      @(negedge clk);
      rec[k] = dut_v;
      total++;
      if (dut_v !== e) begin
        bad++;
        $display("FAIL cycle%0d op=%0d fn=%b: got %b want %b",
                 k, o, fn, dut_v, e);
      end
      if (k == 1) mcx = holds(c, mflags);
      if (k == 2 && o == 2'd0 && lat == 4 && mcx) begin
        if (fn[0] || cmp) mflags[3:2] = aluflags[3:2];
        if ((fn[0] && (add || sub)) || cmp)
          mflags[1:0] = aluflags[1:0];
      end
      if (!(n > 0 && k == cnt - 1)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    logic [1:0] o;
    logic [5:0] fn;
    logic [3:0] r, c;
    logic [3:0] tbl [0:5];
    tbl[0] = 4'b0100; tbl[1] = 4'b0010; tbl[2] = 4'b0000;
    tbl[3] = 4'b1100; tbl[4] = 4'b0001; tbl[5] = 4'b1010;
    reset = 1'b1;
    op = 2'd0; funct = 6'd0; rd = 4'd0; cond = 4'hE;
    aluflags = 4'd0;
    mflags = 4'd0; mcx = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit("rst_irwrite", irwrite, 1'b0);
    lit("rst_pcwrite", pcwrite, 1'b0);
    lit("rst_undef", undef, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // store interrupted by reset while in MEMWRITE
    run_instr(2'd1, 6'b011000, 4'd2, 4'hE, 4'd0, 4);
    lit("str_memwrite", rec[3][MEMW], 1'b1);
    #2 reset = 1'b1;
    #1;
    lit("rst_memwrite_drop", memwrite, 1'b0);
    lit("rst_mid_irwrite", irwrite, 1'b0);
    mflags = 4'd0; mcx = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // ADDS r1 sets Z
    run_instr(2'd0, 6'b001001, 4'd1, 4'hE, 4'b0100, 0);
    lit("adds_fetch_irwrite", rec[0][IRW], 1'b1);
    lit("adds_regwrite", rec[3][REGW], 1'b1);
    lit("adds_lat", last_lat, 4);
    lit("adds_model_flags", mflags, 4'b0100);

    // CMP then BEQ
    run_instr(2'd0, 6'b010101, 4'd0, 4'hE, 4'b0100, 0);
    lit("cmp_regwrite", rec[3][REGW], 1'b0);
    run_instr(2'd2, 6'b000000, 4'd0, 4'h0, 4'd0, 0);
    lit("beq_pcwrite", rec[2][PCW], 1'b1);

    // BNE with Z set
    run_instr(2'd2, 6'b000000, 4'd0, 4'h1, 4'd0, 0);
    lit("bne_pcwrite", rec[2][PCW], 1'b0);
    lit("bne_lat", last_lat, 3);

    // LDR into PC
    run_instr(2'd1, 6'b011001, 4'hF, 4'hE, 4'd0, 0);
    lit("ldrpc_regwrite", rec[4][REGW], 1'b1);
    lit("ldrpc_pcwrite", rec[4][PCW], 1'b1);
    lit("ldrpc_lat", last_lat, 5);

    // op=11 is undefined
    run_instr(2'd3, 6'b000000, 4'd0, 4'hE, 4'd0, 0);
    lit("undef_pulse", rec[1][UND], 1'b1);
    lit("undef_no_we", rec[1][18:15], 4'b0000);
    run_instr(2'd0, 6'b101000, 4'd3, 4'hE, 4'd0, 0);
    lit("after_undef_fetch", rec[0][IRW], 1'b1);

    // randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      o = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      if (o == 2'd0 && $urandom_range(0, 3) != 0)
        fn[4:1] = tbl[$urandom_range(0, 5)];
      r = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      c = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
      run_instr(o, fn, r, c, 4'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
